// File: rtl/alu_op_sequencer_if.sv
// Control bus between the ALU step sequencer and the datapath: start/IR in, step strobes out.
// mem_ready exists only when MEM_WAIT_EN is defined.
interface alu_op_sequencer_if #(
    parameter int NUM_REGS = 16,
    parameter int OP_WIDTH = 5
);
    logic                start;
    logic [31:0]         IR;
`ifdef MEM_WAIT_EN
    logic                mem_ready;
`endif
    logic                PCout, MARin, IncPC;
    logic                PCin, Read, MDRin;
    logic                MDRout, IRin;
    logic                Yin, ZHighin, ZLowin, ZHighout, ZLowout, HIin, LOin;
    logic [NUM_REGS-1:0] Rin;
    logic [NUM_REGS-1:0] Rout;
    logic [OP_WIDTH-1:0] OP;
    logic                busy, done, illegal;

`ifdef MEM_WAIT_EN
    modport master (
        output start, IR, mem_ready,
        input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
               Yin, ZHighin, ZLowin, ZHighout, ZLowout, HIin, LOin,
               Rin, Rout, OP, busy, done, illegal
    );
    modport slave (
        input  start, IR, mem_ready,
        output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
               Yin, ZHighin, ZLowin, ZHighout, ZLowout, HIin, LOin,
               Rin, Rout, OP, busy, done, illegal
    );
`else
    modport master (
        output start, IR,
        input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
               Yin, ZHighin, ZLowin, ZHighout, ZLowout, HIin, LOin,
               Rin, Rout, OP, busy, done, illegal
    );
    modport slave (
        input  start, IR,
        output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
               Yin, ZHighin, ZLowin, ZHighout, ZLowout, HIin, LOin,
               Rin, Rout, OP, busy, done, illegal
    );
`endif
endinterface

// File: rtl/alu_op_sequencer.sv
// Hardwired T0..T6 control-step sequencer for register-to-register ALU instructions.
// Define MEM_WAIT_EN to stall the T1 memory read on bus.mem_ready.
module alu_op_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int OP_WIDTH = 5
) (
    input  logic              Clock,
    input  logic              Clear,
    alu_op_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    state_t state_q, state_d;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_wide, is_unary, bad_op, bad_reg, is_illegal;
    logic       mem_ok;

    assign opcode = bus.IR[31:27];
    assign ra     = bus.IR[26:23];
    assign rb     = bus.IR[22:19];
    assign rc     = bus.IR[18:15];

    assign is_wide  = (opcode == 5'd15) || (opcode == 5'd16);
    assign is_unary = (opcode == 5'd17) || (opcode == 5'd18);
    assign bad_op   = (opcode >= 5'd19);
    // Unary ops never read rc, so an out-of-range rc only rejects binary/MUL/DIV.
    assign bad_reg  = ({1'b0, ra} >= 5'(NUM_REGS)) ||
                      ({1'b0, rb} >= 5'(NUM_REGS)) ||
                      (!is_unary && ({1'b0, rc} >= 5'(NUM_REGS)));
    assign is_illegal = bad_op || bad_reg;

`ifdef MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    if (mem_ok) state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = is_illegal ? S_IDLE : S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = is_wide ? S_T6 : S_IDLE;
            S_T6:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Outputs stay combinational on state_q/IR: IR is reloaded on the same edge
    // that enters T3, so a registered decode would see the previous instruction.
    logic       rin_en, rout_en;
    logic [3:0] rin_idx, rout_idx;

    always_comb begin
        bus.PCout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.IncPC    = 1'b0;
        bus.PCin     = 1'b0;
        bus.Read     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.ZHighin  = 1'b0;
        bus.ZLowin   = 1'b0;
        bus.ZHighout = 1'b0;
        bus.ZLowout  = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.OP       = '0;
        bus.done     = 1'b0;
        bus.illegal  = 1'b0;
        bus.busy     = (state_q != S_IDLE);
        rin_en       = 1'b0;
        rin_idx      = 4'd0;
        rout_en      = 1'b0;
        rout_idx     = 4'd0;
        case (state_q)
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
            end
            S_T1: begin
                bus.Read  = 1'b1;
                bus.PCin  = mem_ok;
                bus.MDRin = mem_ok;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                if (is_illegal) begin
                    bus.illegal = 1'b1;
                end else if (!is_unary) begin
                    rout_en  = 1'b1;
                    rout_idx = rb;
                    bus.Yin  = 1'b1;
                end
            end
            S_T4: begin
                rout_en     = 1'b1;
                rout_idx    = is_unary ? rb : rc;
                bus.OP      = OP_WIDTH'(opcode);
                bus.ZLowin  = 1'b1;
                bus.ZHighin = is_wide;
            end
            S_T5: begin
                bus.ZLowout = 1'b1;
                if (is_wide) begin
                    bus.LOin = 1'b1;
                end else begin
                    rin_en   = 1'b1;
                    rin_idx  = ra;
                    bus.done = 1'b1;
                end
            end
            S_T6: begin
                bus.ZHighout = 1'b1;
                bus.HIin     = 1'b1;
                bus.done     = 1'b1;
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_sel
        assign bus.Rin[i]  = rin_en  && (rin_idx  == 4'(i));
        assign bus.Rout[i] = rout_en && (rout_idx == 4'(i));
    end

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            assert ($onehot0(bus.Rin));
            assert ($onehot0(bus.Rout));
            assert ($onehot0({bus.PCout, bus.MDRout, |bus.Rout, bus.ZLowout, bus.ZHighout}));
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a 16-register and an 8-register instance, step-by-step strobe checks.
module tb_alu_op_sequencer;
    localparam logic [17:0] PCOUT  = 18'd1 << 17;
    localparam logic [17:0] MARIN  = 18'd1 << 16;
    localparam logic [17:0] INCPC  = 18'd1 << 15;
    localparam logic [17:0] PCIN   = 18'd1 << 14;
    localparam logic [17:0] READ   = 18'd1 << 13;
    localparam logic [17:0] MDRIN  = 18'd1 << 12;
    localparam logic [17:0] MDROUT = 18'd1 << 11;
    localparam logic [17:0] IRIN   = 18'd1 << 10;
    localparam logic [17:0] YIN    = 18'd1 << 9;
    localparam logic [17:0] ZHIN   = 18'd1 << 8;
    localparam logic [17:0] ZLIN   = 18'd1 << 7;
    localparam logic [17:0] ZHOUT  = 18'd1 << 6;
    localparam logic [17:0] ZLOUT  = 18'd1 << 5;
    localparam logic [17:0] HIIN   = 18'd1 << 4;
    localparam logic [17:0] LOIN   = 18'd1 << 3;
    localparam logic [17:0] BUSY   = 18'd1 << 2;
    localparam logic [17:0] DONE   = 18'd1 << 1;
    localparam logic [17:0] ILL    = 18'd1;

    logic Clock = 1'b0;
    logic Clear = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 Clock = ~Clock;

    alu_op_sequencer_if #(.NUM_REGS(16), .OP_WIDTH(5)) a_if ();
    alu_op_sequencer_if #(.NUM_REGS(8),  .OP_WIDTH(5)) b_if ();

    alu_op_sequencer #(.NUM_REGS(16), .OP_WIDTH(5)) dut_a (.Clock(Clock), .Clear(Clear), .bus(a_if));
    alu_op_sequencer #(.NUM_REGS(8),  .OP_WIDTH(5)) dut_b (.Clock(Clock), .Clear(Clear), .bus(b_if));

    wire [17:0] a_ctl = {a_if.PCout, a_if.MARin, a_if.IncPC, a_if.PCin, a_if.Read, a_if.MDRin,
                         a_if.MDRout, a_if.IRin, a_if.Yin, a_if.ZHighin, a_if.ZLowin, a_if.ZHighout,
                         a_if.ZLowout, a_if.HIin, a_if.LOin, a_if.busy, a_if.done, a_if.illegal};
    wire [17:0] b_ctl = {b_if.PCout, b_if.MARin, b_if.IncPC, b_if.PCin, b_if.Read, b_if.MDRin,
                         b_if.MDRout, b_if.IRin, b_if.Yin, b_if.ZHighin, b_if.ZLowin, b_if.ZHighout,
                         b_if.ZLowout, b_if.HIin, b_if.LOin, b_if.busy, b_if.done, b_if.illegal};

    function automatic logic [63:0] obs(input bit b);
        if (b) return {9'd0, b_ctl, 16'(b_if.Rin), 16'(b_if.Rout), b_if.OP};
        return {9'd0, a_ctl, a_if.Rin, a_if.Rout, a_if.OP};
    endfunction

    function automatic logic [63:0] E(input logic [17:0] c, input logic [15:0] ri,
                                      input logic [15:0] ro, input logic [4:0] op);
        return {9'd0, c, ri, ro, op};
    endfunction

    function automatic logic [15:0] oh(input int i);
        return 16'd1 << i;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic exp_step(input string tag, input bit b, input logic [63:0] e);
        chk(tag, obs(b), e);
        tick;
    endtask

    // Drives start for one edge; returns with the DUT in T0.
    task automatic launch(input bit b, input logic [31:0] ir);
        if (b) begin b_if.IR = ir; b_if.start = 1'b1; end
        else   begin a_if.IR = ir; a_if.start = 1'b1; end
        tick;
        a_if.start = 1'b0;
        b_if.start = 1'b0;
    endtask

    task automatic fetch(input string tag, input bit b);
        exp_step({tag, "_t0"}, b, E(PCOUT | MARIN | INCPC | BUSY, 0, 0, 0));
        exp_step({tag, "_t1"}, b, E(PCIN | READ | MDRIN | BUSY, 0, 0, 0));
        exp_step({tag, "_t2"}, b, E(MDROUT | IRIN | BUSY, 0, 0, 0));
    endtask

    task automatic run_illegal(input string tag, input bit b, input logic [31:0] ir);
        launch(b, ir);
        fetch(tag, b);
        exp_step({tag, "_t3"}, b, E(BUSY | ILL, 0, 0, 0));
        chk({tag, "_idle"}, obs(b), 64'd0);
    endtask

    initial begin
        a_if.start = 1'b0; a_if.IR = 32'd0;
        b_if.start = 1'b0; b_if.IR = 32'd0;
`ifdef MEM_WAIT_EN
        a_if.mem_ready = 1'b1;
        b_if.mem_ready = 1'b1;
`endif
        tick; tick;
        chk("reset_a", obs(0), 64'd0);
        chk("reset_b", obs(1), 64'd0);
        Clear = 1'b0;

        // NEG R0,R1
        launch(0, 32'h88080000);
        fetch("neg", 0);
        exp_step("neg_t3", 0, E(BUSY, 0, 0, 0));
        exp_step("neg_t4", 0, E(BUSY | ZLIN, 0, oh(1), 5'd17));
        exp_step("neg_t5", 0, E(BUSY | ZLOUT | DONE, oh(0), 0, 0));
        chk("neg_idle", obs(0), 64'd0);

        // ADD R2,R3,R4
        launch(0, 32'h191A0000);
        fetch("add", 0);
        exp_step("add_t3", 0, E(BUSY | YIN, 0, oh(3), 0));
        exp_step("add_t4", 0, E(BUSY | ZLIN, 0, oh(4), 5'd3));
        exp_step("add_t5", 0, E(BUSY | ZLOUT | DONE, oh(2), 0, 0));
        chk("add_idle", obs(0), 64'd0);

        // MUL rb=2 rc=3
        launch(0, 32'h7811A000);
        fetch("mul", 0);
        exp_step("mul_t3", 0, E(BUSY | YIN, 0, oh(2), 0));
        exp_step("mul_t4", 0, E(BUSY | ZHIN | ZLIN, 0, oh(3), 5'd15));
        exp_step("mul_t5", 0, E(BUSY | ZLOUT | LOIN, 0, 0, 0));
        exp_step("mul_t6", 0, E(BUSY | ZHOUT | HIIN | DONE, 0, 0, 0));
        chk("mul_idle", obs(0), 64'd0);

        // DIV R5,R6,R15 (rc at top of 16-reg range)
        launch(0, {5'd16, 4'd5, 4'd6, 4'd15, 15'd0});
        fetch("div", 0);
        exp_step("div_t3", 0, E(BUSY | YIN, 0, oh(6), 0));
        exp_step("div_t4", 0, E(BUSY | ZHIN | ZLIN, 0, oh(15), 5'd16));
        exp_step("div_t5", 0, E(BUSY | ZLOUT | LOIN, 0, 0, 0));
        exp_step("div_t6", 0, E(BUSY | ZHOUT | HIIN | DONE, 0, 0, 0));
        chk("div_idle", obs(0), 64'd0);

        run_illegal("ill_op25", 0, {5'd25, 4'd1, 4'd2, 4'd3, 15'd0});
        run_illegal("ill_op19", 0, {5'd19, 4'd1, 4'd2, 4'd3, 15'd0});
        run_illegal("ill_rb9_n8", 1, {5'd3, 4'd1, 4'd9, 4'd2, 15'd0});
        run_illegal("ill_rc8_n8", 1, {5'd0, 4'd1, 4'd2, 4'd8, 15'd0});

        // NOT on 8 regs: ra=7 top of range, rc=12 ignored for unary
        launch(1, {5'd18, 4'd7, 4'd2, 4'd12, 15'd0});
        fetch("not8", 1);
        exp_step("not8_t3", 1, E(BUSY, 0, 0, 0));
        exp_step("not8_t4", 1, E(BUSY | ZLIN, 0, oh(2), 5'd18));
        exp_step("not8_t5", 1, E(BUSY | ZLOUT | DONE, oh(7), 0, 0));
        chk("not8_idle", obs(1), 64'd0);

        // Binary op 14 with R0 as destination on 8 regs
        launch(1, {5'd14, 4'd0, 4'd7, 4'd1, 15'd0});
        fetch("op14", 1);
        exp_step("op14_t3", 1, E(BUSY | YIN, 0, oh(7), 0));
        exp_step("op14_t4", 1, E(BUSY | ZLIN, 0, oh(1), 5'd14));
        exp_step("op14_t5", 1, E(BUSY | ZLOUT | DONE, oh(0), 0, 0));

        // Clear in T4 aborts the instruction
        launch(0, 32'h191A0000);
        fetch("clr", 0);
        exp_step("clr_t3", 0, E(BUSY | YIN, 0, oh(3), 0));
        chk("clr_t4", obs(0), E(BUSY | ZLIN, 0, oh(4), 5'd3));
        Clear = 1'b1;
        tick;
        Clear = 1'b0;
        chk("clr_abort", obs(0), 64'd0);
        tick;
        chk("clr_stay", obs(0), 64'd0);

        // Clear wins over start
        Clear = 1'b1; a_if.start = 1'b1;
        tick;
        Clear = 1'b0; a_if.start = 1'b0;
        chk("clr_prio", obs(0), 64'd0);

        // start during T2 is neither honoured nor queued
        launch(0, 32'h88080000);
        exp_step("ign_t0", 0, E(PCOUT | MARIN | INCPC | BUSY, 0, 0, 0));
        exp_step("ign_t1", 0, E(PCIN | READ | MDRIN | BUSY, 0, 0, 0));
        a_if.start = 1'b1;
        exp_step("ign_t2", 0, E(MDROUT | IRIN | BUSY, 0, 0, 0));
        a_if.start = 1'b0;
        exp_step("ign_t3", 0, E(BUSY, 0, 0, 0));
        exp_step("ign_t4", 0, E(BUSY | ZLIN, 0, oh(1), 5'd17));
        exp_step("ign_t5", 0, E(BUSY | ZLOUT | DONE, oh(0), 0, 0));
        exp_step("ign_idle", 0, 64'd0);
        chk("ign_noqueue", obs(0), 64'd0);

        // start held high relaunches after one IDLE cycle
        a_if.IR = 32'h88080000;
        a_if.start = 1'b1;
        tick;
        fetch("hold", 0);
        exp_step("hold_t3", 0, E(BUSY, 0, 0, 0));
        exp_step("hold_t4", 0, E(BUSY | ZLIN, 0, oh(1), 5'd17));
        exp_step("hold_t5", 0, E(BUSY | ZLOUT | DONE, oh(0), 0, 0));
        exp_step("hold_idle", 0, 64'd0);
        chk("hold_relaunch", obs(0), E(PCOUT | MARIN | INCPC | BUSY, 0, 0, 0));
        a_if.start = 1'b0;
        Clear = 1'b1;
        tick;
        Clear = 1'b0;
        chk("hold_flush", obs(0), 64'd0);

`ifdef MEM_WAIT_EN
        // Three wait cycles on the T1 read
        launch(0, 32'h88080000);
        a_if.mem_ready = 1'b0;
        exp_step("mw_t0", 0, E(PCOUT | MARIN | INCPC | BUSY, 0, 0, 0));
        for (int i = 0; i < 3; i++) exp_step("mw_wait", 0, E(READ | BUSY, 0, 0, 0));
        a_if.mem_ready = 1'b1;
        exp_step("mw_t1", 0, E(PCIN | READ | MDRIN | BUSY, 0, 0, 0));
        exp_step("mw_t2", 0, E(MDROUT | IRIN | BUSY, 0, 0, 0));
        exp_step("mw_t3", 0, E(BUSY, 0, 0, 0));
        exp_step("mw_t4", 0, E(BUSY | ZLIN, 0, oh(1), 5'd17));
        exp_step("mw_t5", 0, E(BUSY | ZLOUT | DONE, oh(0), 0, 0));
        chk("mw_idle", obs(0), 64'd0);

        // Clear during a wait
        launch(0, 32'h88080000);
        a_if.mem_ready = 1'b0;
        exp_step("mwc_t0", 0, E(PCOUT | MARIN | INCPC | BUSY, 0, 0, 0));
        chk("mwc_wait", obs(0), E(READ | BUSY, 0, 0, 0));
        Clear = 1'b1;
        tick;
        Clear = 1'b0;
        a_if.mem_ready = 1'b1;
        chk("mwc_abort", obs(0), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
